// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side feeds bytes and consumes writes; the slave side is the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed, XOR-checksummed image byte by byte,
// writes little-endian words into instruction memory, releases the core on success.
module imem_loader #(
    parameter int unsigned ADDR_W     = 6,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_rst_n,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state, state_d;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last;
    logic [7:0]        acc;
    logic [23:0]       shift_buf;
    logic              rx_en_c;
    logic              xfer_c;
    logic              len_ovf_c;
    logic              enter_len_c;

    // Status outputs are pure decodes of the state register.
    assign rx_en_c    = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign bus.rx_ready = rx_en_c;
    assign busy       = rx_en_c;
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign core_rst_n = (state == S_DONE);

    assign xfer_c      = bus.rx_valid && rx_en_c;
    assign len_ovf_c   = (32'(bus.rx_data) >= DEPTH);
    assign enter_len_c = (state_d == S_LEN) && (state != S_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (AUTO_START || start) state_d = S_LEN;
            S_LEN:  if (xfer_c) state_d = len_ovf_c ? S_ERR : S_DATA;
            S_DATA: if (xfer_c && (byte_idx == 2'd3) && (word_idx == last)) state_d = S_CHK;
            S_CHK:  if (xfer_c) state_d = (bus.rx_data == acc) ? S_DONE : S_ERR;
            S_DONE, S_ERR: if (start) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Word assembly, checksum accumulation and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx  <= 2'd0;
            word_idx  <= '0;
            last      <= '0;
            acc       <= 8'd0;
            shift_buf <= 24'd0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= 32'd0;
        end else begin
            bus.we <= 1'b0;
            if (enter_len_c) begin
                byte_idx <= 2'd0;
                word_idx <= '0;
                acc      <= 8'd0;
            end else if (xfer_c) begin
                case (state)
                    S_LEN: begin
                        acc  <= bus.rx_data;
                        last <= ADDR_W'(bus.rx_data);
                    end
                    S_DATA: begin
                        acc      <= acc ^ bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: shift_buf[7:0]   <= bus.rx_data;
                            2'd1: shift_buf[15:8]  <= bus.rx_data;
                            2'd2: shift_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.we    <= 1'b1;
                                bus.waddr <= word_idx;
                                bus.wdata <= {bus.rx_data, shift_buf};
                                // Stop at the last word so the index never wraps.
                                if (word_idx != last) word_idx <= word_idx + ADDR_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as frames are
// sent and popped as the write strobe appears.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_rst_n, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .AUTO_START(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[64];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected transfer", tag);
    endtask

    // Advance one cycle, sample after the edge, score any write strobe.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(bus.waddr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("waddr", 32'(bus.waddr), 32'(e.addr));
                check("wdata", bus.wdata, e.data);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit xfer;
        xfer = 1'b0;
        for (int i = 0; i < 64 && !xfer; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                tick();
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = b;
                xfer = bus.rx_ready;
                tick();
            end
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        if (!xfer) fail_now("xfer_timeout");
    endtask

    task automatic send_frame(input logic [7:0] len, input int nwords,
                              input logic [7:0] sum_xor, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        wr_t        e;
        cs = len;
        send_byte(len, gaps);
        check("core_rst_n_loading", 32'(core_rst_n), 32'd0);
        check("busy_loading", 32'(busy), 32'd1);
        for (int w = 0; w < nwords; w++) begin
            e.addr = ADDR_W'(w);
            e.data = img[w];
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                b  = img[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gaps);
            end
        end
        send_byte(cs ^ sum_xor, gaps);
    endtask

    task automatic rearm();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rearm_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
    endtask

    task automatic check_status(input bit exp_done, input bit exp_err);
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(exp_err));
        check("core_rst_n", 32'(core_rst_n), 32'(exp_done));
        check("rx_ready_idle", 32'(bus.rx_ready), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
        check({tag, "_wdata"}, bus.wdata, 32'd0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic set_nominal();
        img[0] = 32'h0050_0093;
        img[1] = 32'h0010_8113;
    endtask

    initial begin
        wr_t e;
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) tick();
        check_reset_outputs("reset");

        // Auto-start: LEN on the first clock after release.
        rst = 1'b0;
        tick();
        check("autostart_busy", 32'(busy), 32'd1);
        check("autostart_rx_ready", 32'(bus.rx_ready), 32'd1);

        // Nominal two-word image, checksum 0x40.
        set_nominal();
        send_frame(8'h01, 2, 8'h00, 1'b0);
        check_status(1'b1, 1'b0);

        // Re-arm and load a single word.
        rearm();
        img[0] = 32'h0000_0013;
        send_frame(8'h00, 1, 8'h00, 1'b0);
        check_status(1'b1, 1'b0);

        // Bad checksum 0x41: writes still happen, then ERR.
        rearm();
        set_nominal();
        send_frame(8'h01, 2, 8'h01, 1'b0);
        check_status(1'b0, 1'b1);

        // Length overflow: 0x40 means 65 words for a 64-word memory.
        rearm();
        send_byte(8'h40, 1'b0);
        repeat (3) tick();
        check_status(1'b0, 1'b1);

        // Gaps with garbage data while invalid.
        rearm();
        set_nominal();
        send_frame(8'h01, 2, 8'h00, 1'b1);
        check_status(1'b1, 1'b0);

        // Full memory: last write lands at 63.
        rearm();
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        send_frame(8'h3F, 64, 8'h00, 1'b0);
        check_status(1'b1, 1'b0);
        check("full_last_waddr", 32'(bus.waddr), 32'd63);
        check("full_last_wdata", bus.wdata, img[63]);

        // Reset mid-DATA, asserted between clock edges.
        rearm();
        send_byte(8'h3F, 1'b0);
        for (int w = 0; w < 10; w++) begin
            e.addr = ADDR_W'(w);
            e.data = img[w];
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], 1'b0);
        end
        send_byte(img[10][7:0], 1'b0);
        send_byte(img[10][15:8], 1'b0);
        check("pre_reset_waddr", 32'(bus.waddr), 32'd9);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        check("async_reset_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        set_nominal();
        send_frame(8'h01, 2, 8'h00, 1'b0);
        check_status(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
